// File: rtl/latch_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : latch_mon_pkg
// Purpose  : Shared types and default constants for latch_edge_monitor.
//            Holds the debounce FSM state encoding and the event record that
//            is captured on each committed transition.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package latch_mon_pkg;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_CNT_W           = 8;

    // Widest transition counter the event record can carry.
    localparam int MAX_CNT_W = 32;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

    typedef struct packed {
        logic                 rise;
        logic                 illegal;
        logic [MAX_CNT_W-1:0] count;
    } evt_t;

endpackage
`default_nettype wire

// File: rtl/latch_edge_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : latch_edge_monitor_if
// Purpose  : Single-entry valid/ready event channel carrying one committed
//            latch transition (direction, illegal flag, running count).
// Ports    : valid   - event register occupied        (master -> slave)
//            ready   - consumer accepts the event      (slave  -> master)
//            rise    - 1 rising, 0 falling             (master -> slave)
//            illegal - committed while EN was low      (master -> slave)
//            count   - transition count incl. this one (master -> slave)
// Revision : 1.0  initial release
// ============================================================================
interface latch_edge_monitor_if
    import latch_mon_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);
    logic             valid;
    logic             ready;
    logic             rise;
    logic             illegal;
    logic [CNT_W-1:0] count;

    modport master (output valid, output rise, output illegal, output count, input ready);
    modport slave  (input valid, input rise, input illegal, input count, output ready);
endinterface
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : bit_sync
// Purpose  : One-bit multi-flop synchroniser, synchronous reset to 0.
// Ports    : clk - destination clock
//            rst - synchronous active-high reset
//            d   - asynchronous input
//            q   - synchronised output (last flop of the chain)
// Revision : 1.0  initial release
// ============================================================================
module bit_sync
    import latch_mon_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES   // >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/latch_edge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : latch_edge_monitor
// Purpose  : Observer for a d_latch output. Synchronises Q and EN, debounces
//            Q, and reports each committed transition as a rise/fall event
//            with a running count. Commits made while EN is low are flagged.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            q_in, en_in  - latch Q and EN (asynchronous to clk)
//            clr          - clears edge_count, err_illegal, err_ovf
//            evt          - event channel (master side)
//            q_stable     - debounced latch level
//            edge_count   - committed transitions, wrapping
//            err_illegal  - sticky, commit seen with EN low
//            err_ovf      - sticky, event dropped on a full register
// Revision : 1.0  initial release
// ============================================================================
module latch_edge_monitor
    import latch_mon_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,      // >= 2
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,  // >= 1
    parameter int CNT_W           = DEFAULT_CNT_W             // 1..MAX_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  q_in,
    input  logic                  en_in,
    input  logic                  clr,
    latch_edge_monitor_if.master  evt,
    output logic                  q_stable,
    output logic [CNT_W-1:0]      edge_count,
    output logic                  err_illegal,
    output logic                  err_ovf
);

    localparam int               RUN_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RUN_W-1:0] c_run_limit = RUN_W'(DEBOUNCE_CYCLES);

    logic             w_q_sync;
    logic             w_en_sync;
    logic             w_mismatch;
    logic [RUN_W-1:0] w_run_next;
    logic             w_commit;
    logic             w_illegal;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;

    deb_state_t       r_state;
    logic [RUN_W-1:0] r_run_cnt;
    logic             r_q_stable;
    logic [CNT_W-1:0] r_edge_count;
    logic             r_err_illegal;
    logic             r_err_ovf;
    logic             r_evt_valid;
    evt_t             r_evt;

    bit_sync #(.STAGES(SYNC_STAGES)) u_q_sync (
        .clk (clk),
        .rst (rst),
        .d   (q_in),
        .q   (w_q_sync)
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_en_sync (
        .clk (clk),
        .rst (rst),
        .d   (en_in),
        .q   (w_en_sync)
    );

    // A commit happens on the edge where the mismatch run reaches its limit,
    // so the run counter never actually holds DEBOUNCE_CYCLES.
    assign w_mismatch = w_q_sync ^ r_q_stable;
    assign w_run_next = (r_state == PENDING) ? (r_run_cnt + RUN_W'(1)) : RUN_W'(1);
    assign w_commit   = w_mismatch && (w_run_next == c_run_limit);
    assign w_illegal  = ~w_en_sync;

    // A coincident clear restarts the count before this commit is added.
    assign w_cnt_base = clr ? '0 : r_edge_count;
    assign w_cnt_next = w_cnt_base + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= STABLE;
            r_run_cnt  <= '0;
            r_q_stable <= 1'b0;
        end else if (w_mismatch) begin
            if (w_commit) begin
                r_state    <= STABLE;
                r_run_cnt  <= '0;
                r_q_stable <= w_q_sync;
            end else begin
                r_state    <= PENDING;
                r_run_cnt  <= w_run_next;
            end
        end else begin
            // Synced level fell back to the stable level: glitch rejected.
            r_state   <= STABLE;
            r_run_cnt <= '0;
        end
    end

    // Clear is written first so a same-edge commit overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_count  <= '0;
            r_err_illegal <= 1'b0;
            r_err_ovf     <= 1'b0;
            r_evt_valid   <= 1'b0;
            r_evt         <= '0;
        end else begin
            if (clr) begin
                r_edge_count  <= '0;
                r_err_illegal <= 1'b0;
                r_err_ovf     <= 1'b0;
            end
            if (w_commit) begin
                r_edge_count <= w_cnt_next;
                if (w_illegal) begin
                    r_err_illegal <= 1'b1;
                end
                if (!r_evt_valid || evt.ready) begin
                    r_evt_valid <= 1'b1;
                    r_evt       <= '{rise: w_q_sync, illegal: w_illegal,
                                     count: MAX_CNT_W'(w_cnt_next)};
                end else begin
                    r_err_ovf <= 1'b1;
                end
            end else if (r_evt_valid && evt.ready) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    // The record's count field is sized for the widest counter; bits above
    // CNT_W are always zero and intentionally go nowhere.
    if (CNT_W < MAX_CNT_W) begin : g_count_pad
        logic unused_count_hi;
        assign unused_count_hi = |r_evt.count[MAX_CNT_W-1:CNT_W];
    end

    assign evt.valid   = r_evt_valid;
    assign evt.rise    = r_evt.rise;
    assign evt.illegal = r_evt.illegal;
    assign evt.count   = r_evt.count[CNT_W-1:0];
    assign q_stable    = r_q_stable;
    assign edge_count  = r_edge_count;
    assign err_illegal = r_err_illegal;
    assign err_ovf     = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_latch_edge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_edge_monitor
// Purpose  : Self-checking bench for latch_edge_monitor. Two instances share
//            stimulus: one with an 8-bit counter, one with a 2-bit counter
//            (exercises wrap). A window-based reference model is compared
//            every cycle; a vector table and hand sequences add fixed checks.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_latch_edge_monitor;
    import latch_mon_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic q_in  = 1'b0;
    logic en_in = 1'b0;
    logic clr   = 1'b0;
    logic ready = 1'b0;

    latch_edge_monitor_if #(.CNT_W(8)) evt8 ();
    latch_edge_monitor_if #(.CNT_W(2)) evt2 ();
    assign evt8.ready = ready;
    assign evt2.ready = ready;

    logic       qs8, qs2, ei8, ei2, eo8, eo2;
    logic [7:0] ec8;
    logic [1:0] ec2;

    latch_edge_monitor #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .q_in(q_in), .en_in(en_in), .clr(clr), .evt(evt8),
        .q_stable(qs8), .edge_count(ec8), .err_illegal(ei8), .err_ovf(eo8));

    latch_edge_monitor #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .q_in(q_in), .en_in(en_in), .clr(clr), .evt(evt2),
        .q_stable(qs2), .edge_count(ec2), .err_illegal(ei2), .err_ovf(eo2));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Sync: the value seen by the monitor is the input sampled SYNC edges ago.
    // Debounce: commit when the last DEB synced samples all differ from the
    // stable level.
    bit m_q_smp[$];
    bit m_e_smp[$];
    bit m_win[$];
    bit m_stable, m_valid, m_rise, m_ill, m_ei, m_eo;
    int m_cnt, m_pcnt;

    task automatic model_edge();
        bit qsync, esync, commit;
        if (rst) begin
            m_q_smp.delete(); m_e_smp.delete(); m_win.delete();
            m_stable = 0; m_valid = 0; m_rise = 0; m_ill = 0;
            m_ei = 0; m_eo = 0; m_cnt = 0; m_pcnt = 0;
            return;
        end
        qsync = (m_q_smp.size() == SYNC) ? m_q_smp[0] : 1'b0;
        esync = (m_e_smp.size() == SYNC) ? m_e_smp[0] : 1'b0;
        m_q_smp.push_back(q_in);
        m_e_smp.push_back(en_in);
        if (m_q_smp.size() > SYNC) void'(m_q_smp.pop_front());
        if (m_e_smp.size() > SYNC) void'(m_e_smp.pop_front());
        m_win.push_back(qsync);
        if (m_win.size() > DEB) void'(m_win.pop_front());
        commit = (m_win.size() == DEB);
        foreach (m_win[i]) if (m_win[i] == m_stable) commit = 0;

        if (clr) begin m_cnt = 0; m_ei = 0; m_eo = 0; end
        if (commit) begin
            m_stable = qsync;
            m_cnt    = (m_cnt + 1) % 256;
            if (!esync) m_ei = 1;
            if (!m_valid || ready) begin
                m_valid = 1; m_rise = qsync; m_ill = !esync; m_pcnt = m_cnt;
            end else begin
                m_eo = 1;
            end
        end else if (m_valid && ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        chk("m.valid8", evt8.valid,   m_valid);
        chk("m.valid2", evt2.valid,   m_valid);
        chk("m.rise8",  evt8.rise,    m_rise);
        chk("m.ill8",   evt8.illegal, m_ill);
        chk("m.cnt8",   evt8.count,   m_pcnt);
        chk("m.cnt2",   evt2.count,   m_pcnt % 4);
        chk("m.qs8",    qs8,          m_stable);
        chk("m.qs2",    qs2,          m_stable);
        chk("m.ec8",    ec8,          m_cnt);
        chk("m.ec2",    ec2,          m_cnt % 4);
        chk("m.ei8",    ei8,          m_ei);
        chk("m.eo8",    eo8,          m_eo);
        chk("m.ei2",    ei2,          m_ei);
        chk("m.eo2",    eo2,          m_eo);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit q; bit en; bit clr; bit rdy; int cyc;
        bit valid; bit rise; bit ill; int cnt; bit qs; int ec; bit ei; bit eo;
    } vec_t;

    vec_t tbl[13];
    int   exp_wrap[5];
    int   seen;

    initial begin
        //           q    en   clr  rdy  cyc   valid rise ill  cnt qs   ec ei   eo
        tbl[0]  = '{1'b0,1'b1,1'b0,1'b1,10,   1'b0,1'b0,1'b0,0, 1'b0,0, 1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b1,1'b0,1'b1, 5,   1'b0,1'b0,1'b0,0, 1'b0,0, 1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b1, 1,   1'b1,1'b1,1'b0,1, 1'b1,1, 1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b1, 1,   1'b0,1'b1,1'b0,1, 1'b1,1, 1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b1, 2,   1'b0,1'b1,1'b0,1, 1'b1,1, 1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b1, 8,   1'b0,1'b1,1'b0,1, 1'b1,1, 1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b1, 5,   1'b0,1'b1,1'b0,1, 1'b1,1, 1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b1, 1,   1'b1,1'b0,1'b1,2, 1'b0,2, 1'b1,1'b0};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b1, 6,   1'b0,1'b0,1'b1,2, 1'b0,2, 1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b1, 1,   1'b0,1'b0,1'b1,2, 1'b0,0, 1'b0,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b0,1'b0, 6,   1'b1,1'b1,1'b0,1, 1'b1,1, 1'b0,1'b0};
        tbl[11] = '{1'b0,1'b1,1'b0,1'b0,10,   1'b1,1'b1,1'b0,1, 1'b0,2, 1'b0,1'b1};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b1, 1,   1'b0,1'b1,1'b0,1, 1'b0,2, 1'b0,1'b1};
        exp_wrap = '{1, 2, 3, 0, 1};

        // reset state
        rst = 1'b1;
        repeat (3) step();
        chk("reset.valid", evt8.valid, 0);
        chk("reset.qs",    qs8, 0);
        rst = 1'b0;

        // table-driven vectors
        for (int i = 0; i < 13; i++) begin
            q_in = tbl[i].q; en_in = tbl[i].en; clr = tbl[i].clr; ready = tbl[i].rdy;
            for (int c = 0; c < tbl[i].cyc; c++) step();
            chk($sformatf("vec%0d.valid", i), evt8.valid,   tbl[i].valid);
            chk($sformatf("vec%0d.rise", i),  evt8.rise,    tbl[i].rise);
            chk($sformatf("vec%0d.ill", i),   evt8.illegal, tbl[i].ill);
            chk($sformatf("vec%0d.cnt", i),   evt8.count,   tbl[i].cnt);
            chk($sformatf("vec%0d.qs", i),    qs8,          tbl[i].qs);
            chk($sformatf("vec%0d.ec8", i),   ec8,          tbl[i].ec);
            chk($sformatf("vec%0d.ec2", i),   ec2,          tbl[i].ec % 4);
            chk($sformatf("vec%0d.ei", i),    ei8,          tbl[i].ei);
            chk($sformatf("vec%0d.eo", i),    eo8,          tbl[i].eo);
        end
        clr = 1'b0;

        // wrap with the 2-bit counter, then clear coincident with a commit
        ready = 1'b1;
        clr = 1'b1; step(); clr = 1'b0;
        chk("wrap.cleared", ec2, 0);
        for (int i = 0; i < 5; i++) begin
            q_in = ~q_in;
            repeat (6) step();
            chk($sformatf("wrap%0d.valid", i), evt2.valid, 1);
            chk($sformatf("wrap%0d.ec2", i),   ec2, exp_wrap[i]);
            chk($sformatf("wrap%0d.ec8", i),   ec8, i + 1);
        end
        q_in = ~q_in;
        repeat (5) step();
        clr = 1'b1; step(); clr = 1'b0;
        chk("clrcommit.ec8",   ec8, 1);
        chk("clrcommit.ec2",   ec2, 1);
        chk("clrcommit.valid", evt8.valid, 1);

        // reset while a debounce is pending
        q_in = ~q_in;
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();
        chk("rstmid.valid", evt8.valid, 0);
        chk("rstmid.qs",    qs8, 0);
        chk("rstmid.ec",    ec8, 0);
        chk("rstmid.cnt",   evt8.count, 0);
        rst = 1'b0;
        q_in = 1'b1;
        seen = -1;
        for (int n = 0; n < 12; n++) begin
            step();
            if (evt8.valid && seen < 0) seen = n;
        end
        chk("rstmid.latency", seen, SYNC + DEB - 1);
        chk("rstmid.rise",    evt8.rise, 1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0)  q_in  = ~q_in;
            if ($urandom_range(15) == 0) en_in = ~en_in;
            clr   = ($urandom_range(63) == 0);
            ready = $urandom_range(1) == 1;
            rst   = ($urandom_range(499) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
